kpscan: RTL and testbench
=========================

Name: kpscan

Overview:
Parametrised scanning keypad controller for an NROWS x NCOLS active-low matrix keypad. It drives the column lines one-cold and samples the row lines. Each scan frame is reduced to none, single or multiple keys. A single-key result is debounced across frames and delivered as a key-index event over a valid/ready handshake, with optional auto-repeat. It sits between the keypad pins and the game/control FSM, and replaces the purely combinational row/column decode with a self-scanning, debounced event source.

Parameters:
NROWS, 4, number of row inputs (>=1)
NCOLS, 4, number of column outputs (>=2)
SCAN_DIV, 1000, clocks each column is driven before its rows are sampled (>=2)
DEBOUNCE, 4, consecutive identical frame results required to commit a change (>=1)
REPEAT_EN, 0, 1 = auto-repeat events while a key is held
REPEAT_DELAY, 50, frames from commit to first repeat event
REPEAT_RATE, 10, frames between subsequent repeat events
KW, $clog2(NROWS*NCOLS), derived key index width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
kpr  in  NROWS  keypad rows, active-low, externally pulled up
kpc  out  NCOLS  column drive, active-low, exactly one bit low at all times
key  out  KW  key index = row*NCOLS + col (row = kpr bit, col = kpc bit)
key_valid  out  1  event pending; held until accepted
key_rdy  in  1  consumer ready; an event transfers when key_valid & key_rdy
key_held  out  1  a single key is committed as pressed
multi  out  1  most recent frame result was multiple keys
overflow  out  1  sticky: an event was dropped while one was pending

Behaviour:
- Reset (synchronous, all state): column index 0, kpc = ~1 (column 0 low), divider 0, debounce count 0, committed state = none. Outputs: key=0, key_valid=0, key_held=0, multi=0, overflow=0.
- Scan: the divider counts 0..SCAN_DIV-1 per column. On count SCAN_DIV-1:
  - OR any low kpr bits into the frame accumulator.
  - Advance the column index and wrap from NCOLS-1 to 0.
  - kpc changes on the following clock edge.
- Frame end: occurs on the last sample of column NCOLS-1. The result is:
  - NONE: no low rows seen.
  - SINGLE(idx): exactly one row/column hit.
  - MULTI: two or more hits in any combination.
  - The accumulator clears for the next frame.
  - multi updates every frame end (1 on MULTI, else 0).
- Debounce: the candidate is the result of the previous frame.
  - If the result equals the candidate, count = min(count+1, DEBOUNCE).
  - Otherwise the candidate becomes the result and count = 1.
  - MULTI never commits; the committed state is held.
- Committed FSM:
  - IDLE -> HELD(idx): when count reaches DEBOUNCE with SINGLE(idx). Generates an event.
  - HELD(a) -> HELD(b), b != a: on a committed SINGLE(b). Generates an event for b.
  - HELD -> IDLE: on a committed NONE. No event.
  - key_held = 1 in HELD.
- Auto-repeat (REPEAT_EN=1 only):
  - The frame counter resets on every commit.
  - In HELD, an event is generated after REPEAT_DELAY frames, then every REPEAT_RATE frames.
  - Leaving HELD stops repeat immediately.
- Event output:
  - key/key_valid are registered and update on the clock after the generating frame end.
  - key_valid stays high and key stays stable until the transfer edge (key_valid & key_rdy). key_valid falls on that edge unless a new event is generated in the same cycle; in that case the new event is loaded.
  - An event generated while key_valid=1 and key_rdy=0 is dropped, the old key is kept, and overflow is set until reset.
- Latency: key pressed and stable from the start of frame F -> key_valid rises 1 clock after the end of frame F+DEBOUNCE-1.
- Reset mid-scan or mid-handshake: the pending event is discarded and scanning restarts at column 0 next clock.

Test Plan:
- NROWS=NCOLS=4, SCAN_DIV=4, DEBOUNCE=3. Hold row1/col2 from frame start -> key=6, key_valid rises 1 clk after the 3rd frame end (frame = 16 clk), key_held=1. kpc cycles 1110,1101,1011,0111 with 4 clk per step.
- Same config, key_rdy=1. Bounce: key 6 for 2 frames, none for 1 frame, key 6 for 3 frames -> exactly one event (key=6), committed at the end of the 6th frame; no event during the bounce.
- Hold key 0 with key_rdy=0, release, then press key 15 -> second event dropped, key stays 0, overflow=1. After key_rdy pulse, key_valid=0, overflow still 1.
- Press keys 5 and 9 together while key 5 is committed -> multi=1 each such frame, key_held=1, no new event. Release 9 -> multi=0, no event.
- REPEAT_EN=1, REPEAT_DELAY=2, REPEAT_RATE=1, key_rdy=1, hold key 10 for 8 frames after commit -> events at commit, commit+2, +3, +4 ... +8 frames. Release -> no further events; key_held falls after 3 NONE frames.
- Assert reset for 1 clk with key_valid=1 mid-frame -> next clk all outputs 0, kpc=1110, divider restarts at 0.

Source files
------------

// File: rtl/kpscan.sv
`default_nettype none
// ============================================================================
// Module  : kpscan
// Brief   : Self-scanning, debounced matrix keypad controller with key events.
// Revision: 1.0
// ============================================================================
module kpscan #(
   parameter int NROWS        = 4,
   parameter int NCOLS        = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE     = 4,
   parameter int REPEAT_EN    = 0,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10,
   parameter int KW           = $clog2(NROWS * NCOLS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NROWS-1:0] kpr,
   output logic [NCOLS-1:0] kpc,
   output logic [KW-1:0]    key,
   output logic             key_valid,
   input  logic             key_rdy,
   output logic             key_held,
   output logic             multi,
   output logic             overflow
);

   localparam int DW   = $clog2(SCAN_DIV);
   localparam int CW   = $clog2(NCOLS);
   localparam int BW   = $clog2(DEBOUNCE + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 2);

   localparam logic [DW-1:0] c_DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] c_COL_LAST = CW'(NCOLS - 1);
   localparam logic [BW-1:0] c_DEB      = BW'(DEBOUNCE);
   localparam logic [RW-1:0] c_RDELAY   = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] c_RRATE    = RW'(REPEAT_RATE);

   typedef enum logic [1:0] {
      RES_NONE   = 2'd0,
      RES_SINGLE = 2'd1,
      RES_MULTI  = 2'd2
   } res_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HELD = 1'b1
   } state_t;

   logic [DW-1:0]    r_div;
   logic [CW-1:0]    r_col;
   logic [NCOLS-1:0] r_kpc;
   logic [1:0]       r_acc_n;
   logic [KW-1:0]    r_acc_idx;
   res_t             r_cand;
   logic [KW-1:0]    r_cand_idx;
   logic [BW-1:0]    r_cnt;
   state_t           r_state;
   logic [KW-1:0]    r_held_idx;
   logic [RW-1:0]    r_rfc;
   logic             r_rphase;
   logic [KW-1:0]    r_key;
   logic             r_valid;
   logic             r_multi;
   logic             r_ovf;

   logic             w_sample;
   logic             w_fend;
   logic [CW-1:0]    w_col_nxt;
   logic [1:0]       w_nlow;
   logic [KW-1:0]    w_hit_idx;
   logic [2:0]       w_sum;
   logic [1:0]       w_tot_n;
   logic [KW-1:0]    w_tot_idx;
   res_t             w_res;
   logic [KW-1:0]    w_res_idx;
   logic             w_same;
   logic [BW-1:0]    w_cnt_nxt;
   logic             w_committed;
   logic             w_go_held;
   logic             w_go_idle;
   logic             w_rep_frame;
   logic [RW-1:0]    w_rfc_inc;
   logic             w_rep_hit;
   logic             w_event;
   logic [KW-1:0]    w_ev_key;

   always_comb begin
      w_sample  = (r_div == c_DIV_LAST);
      w_fend    = w_sample && (r_col == c_COL_LAST);
      w_col_nxt = (r_col == c_COL_LAST) ? '0 : r_col + 1'b1;

      // Hit count saturates at 2: anything beyond one hit is simply MULTI.
      w_nlow    = 2'd0;
      w_hit_idx = '0;
      for (int r = 0; r < NROWS; r++) begin
         if (!kpr[r]) begin
            if (w_nlow != 2'd2) w_nlow = w_nlow + 2'd1;
            w_hit_idx = KW'(r * NCOLS + int'(r_col));
         end
      end
      w_sum     = {1'b0, r_acc_n} + {1'b0, w_nlow};
      w_tot_n   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
      w_tot_idx = (r_acc_n == 2'd0) ? w_hit_idx : r_acc_idx;

      case (w_tot_n)
         2'd0:    w_res = RES_NONE;
         2'd1:    w_res = RES_SINGLE;
         default: w_res = RES_MULTI;
      endcase
      w_res_idx = (w_res == RES_SINGLE) ? w_tot_idx : '0;

      w_same    = (w_res == r_cand) && (w_res_idx == r_cand_idx);
      w_cnt_nxt = w_same ? ((r_cnt == c_DEB) ? r_cnt : r_cnt + 1'b1) : BW'(1);

      w_committed = w_fend && (w_cnt_nxt == c_DEB);
      w_go_held   = w_committed && (w_res == RES_SINGLE) &&
                    ((r_state == S_IDLE) || (r_held_idx != w_res_idx));
      w_go_idle   = w_committed && (w_res == RES_NONE) && (r_state == S_HELD);

      // Repeat frames are only those in which the held key is seen on its own.
      w_rep_frame = (REPEAT_EN != 0) && w_fend && (r_state == S_HELD) && !w_go_held &&
                    (w_res == RES_SINGLE) && (w_res_idx == r_held_idx);
      w_rfc_inc   = r_rfc + 1'b1;
      w_rep_hit   = w_rep_frame && (w_rfc_inc == (r_rphase ? c_RRATE : c_RDELAY));

      w_event  = w_go_held || w_rep_hit;
      w_ev_key = w_go_held ? w_res_idx : r_held_idx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_div      <= '0;
         r_col      <= '0;
         r_kpc      <= ~NCOLS'(1);
         r_acc_n    <= 2'd0;
         r_acc_idx  <= '0;
         r_cand     <= RES_NONE;
         r_cand_idx <= '0;
         r_cnt      <= '0;
         r_state    <= S_IDLE;
         r_held_idx <= '0;
         r_rfc      <= '0;
         r_rphase   <= 1'b0;
         r_key      <= '0;
         r_valid    <= 1'b0;
         r_multi    <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_div <= w_sample ? '0 : r_div + 1'b1;

         if (w_sample) begin
            r_col <= w_col_nxt;
            r_kpc <= ~(NCOLS'(1) << w_col_nxt);
            if (w_fend) begin
               r_acc_n   <= 2'd0;
               r_acc_idx <= '0;
            end else begin
               r_acc_n   <= w_tot_n;
               r_acc_idx <= w_tot_idx;
            end
         end

         if (w_fend) begin
            r_multi    <= (w_res == RES_MULTI);
            r_cand     <= w_res;
            r_cand_idx <= w_res_idx;
            r_cnt      <= w_cnt_nxt;
            if (w_go_held) begin
               r_state    <= S_HELD;
               r_held_idx <= w_res_idx;
            end else if (w_go_idle) begin
               r_state    <= S_IDLE;
            end
         end

         if (w_go_held || w_go_idle) begin
            r_rfc    <= '0;
            r_rphase <= 1'b0;
         end else if (w_rep_hit) begin
            r_rfc    <= '0;
            r_rphase <= 1'b1;
         end else if (w_rep_frame) begin
            r_rfc    <= w_rfc_inc;
         end

         // A transfer edge may reload a new event; otherwise a pending one wins.
         if (r_valid && key_rdy) begin
            r_valid <= w_event;
            if (w_event) r_key <= w_ev_key;
         end else if (r_valid) begin
            if (w_event) r_ovf <= 1'b1;
         end else if (w_event) begin
            r_valid <= 1'b1;
            r_key   <= w_ev_key;
         end
      end
   end

   assign kpc       = r_kpc;
   assign key       = r_key;
   assign key_valid = r_valid;
   assign key_held  = (r_state == S_HELD);
   assign multi     = r_multi;
   assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_kpscan.sv
`default_nettype none
// ============================================================================
// Module  : tb_kpscan
// Brief   : Self-checking bench for kpscan with a keypad matrix model.
// Revision: 1.0
// ============================================================================
module tb_kpscan;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pressed;
   logic [3:0]  kpr0, kpr1, kpc0, kpc1, key0, key1;
   logic        v0, v1, rdy0, rdy1, held0, held1, multi0, multi1, ovf0, ovf1;

   int n_tests = 0;
   int n_fail  = 0;
   int ev0, ev1, lk0, lk1;

   always #5 clk = ~clk;

   // Pressed key at bit row*4+col pulls its row low while its column is driven.
   always_comb begin
      kpr0 = 4'hF;
      kpr1 = 4'hF;
      for (int r = 0; r < 4; r++) begin
         kpr0[r] = ~|(pressed[r*4 +: 4] & ~kpc0);
         kpr1[r] = ~|(pressed[r*4 +: 4] & ~kpc1);
      end
   end

   kpscan #(.NROWS(4), .NCOLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_EN(0),
            .REPEAT_DELAY(2), .REPEAT_RATE(1)) dut0 (
      .clk(clk), .reset(reset), .kpr(kpr0), .kpc(kpc0), .key(key0), .key_valid(v0),
      .key_rdy(rdy0), .key_held(held0), .multi(multi0), .overflow(ovf0));

   kpscan #(.NROWS(4), .NCOLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_EN(1),
            .REPEAT_DELAY(2), .REPEAT_RATE(1)) dut1 (
      .clk(clk), .reset(reset), .kpr(kpr1), .kpc(kpc1), .key(key1), .key_valid(v1),
      .key_rdy(rdy1), .key_held(held1), .multi(multi1), .overflow(ovf1));

   typedef struct {
      int         row;
      int         col;
      logic [3:0] exp_key;
   } vec_t;

   vec_t       vt[6];
   logic [3:0] kpc_exp[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (v0) begin ev0++; lk0 = int'(key0); end
      if (v1) begin ev1++; lk1 = int'(key1); end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic run_frames(input int n);
      repeat (16 * n) tick();
   endtask

   function automatic bit rep_expected(input int f, input int dly, input int rate);
      return (f == dly) || (f > dly && ((f - dly) % rate) == 0);
   endfunction

   // Reference model state for the randomized run.
   int res_q[$];
   bit mheld, mvalid, movf, mmulti;
   int mheld_idx, mkey;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nv, first, kk, r, ev_key;
      bit ev, allsame;

      vt[0] = '{1, 2, 4'd6};
      vt[1] = '{0, 0, 4'd0};
      vt[2] = '{3, 3, 4'd15};
      vt[3] = '{2, 1, 4'd9};
      vt[4] = '{0, 3, 4'd3};
      vt[5] = '{3, 0, 4'd12};
      kpc_exp[0] = 4'b1110; kpc_exp[1] = 4'b1101;
      kpc_exp[2] = 4'b1011; kpc_exp[3] = 4'b0111;

      reset = 1'b1; pressed = '0; rdy0 = 1'b0; rdy1 = 1'b1;
      ev0 = 0; ev1 = 0; lk0 = 0; lk1 = 0;
      repeat (3) tick();
      check("reset_key", key0, 0);
      check("reset_valid", v0, 0);
      check("reset_held", held0, 0);
      check("reset_multi", multi0, 0);
      check("reset_ovf", ovf0, 0);
      check("reset_kpc", kpc0, 4'b1110);

      // Single-key press latency, index mapping and column scan.
      foreach (vt[i]) begin
         rdy0 = 1'b0;
         pressed = '0;
         pressed[vt[i].row*4 + vt[i].col] = 1'b1;
         do_reset();
         for (int t = 0; t < 47; t++) begin
            if (t < 16) check("kpc_scan", kpc0, kpc_exp[t/4]);
            tick();
         end
         check("pre_commit_valid", v0, 0);
         tick();
         check("commit_valid", v0, 1);
         check("commit_key", key0, vt[i].exp_key);
         check("commit_held", held0, 1);
         check("commit_multi", multi0, 0);
         rdy0 = 1'b1;
         tick();
         rdy0 = 1'b0;
         check("accept_valid", v0, 0);
      end

      // Bounce: 2 frames key 6, 1 frame none, 3 frames key 6.
      rdy0 = 1'b1; pressed = 16'h0040;
      do_reset();
      nv = 0; first = -1; kk = -1;
      for (int t = 0; t < 112; t++) begin
         if (t == 32) pressed = '0;
         if (t == 48) pressed = 16'h0040;
         tick();
         if (v0) begin
            nv++;
            if (first < 0) first = t + 1;
            kk = int'(key0);
         end
      end
      check("bounce_events", nv, 1);
      check("bounce_time", first, 96);
      check("bounce_key", kk, 6);

      // Overflow: key 0 pending, key 15 committed while not ready.
      rdy0 = 1'b0; pressed = 16'h0001;
      do_reset();
      run_frames(3);
      check("ovf_first_valid", v0, 1);
      check("ovf_first_key", key0, 0);
      pressed = '0;
      run_frames(3);
      check("ovf_release_held", held0, 0);
      check("ovf_release_ovf", ovf0, 0);
      pressed = 16'h8000;
      run_frames(3);
      check("ovf_second_held", held0, 1);
      check("ovf_key_kept", key0, 0);
      check("ovf_valid", v0, 1);
      check("ovf_set", ovf0, 1);
      rdy0 = 1'b1;
      tick();
      rdy0 = 1'b0;
      check("ovf_after_rdy_valid", v0, 0);
      check("ovf_sticky", ovf0, 1);

      // Multi: 5 committed, then 5+9, then 9 released.
      rdy0 = 1'b1; pressed = 16'h0020;
      do_reset();
      ev0 = 0;
      run_frames(3);
      check("multi_commit_ev", ev0, 1);
      check("multi_commit_key", lk0, 5);
      ev0 = 0;
      pressed = 16'h0220;
      for (int f = 0; f < 3; f++) begin
         run_frames(1);
         check("multi_flag", multi0, 1);
         check("multi_held", held0, 1);
      end
      check("multi_no_event", ev0, 0);
      pressed = 16'h0020;
      for (int f = 0; f < 3; f++) begin
         run_frames(1);
         check("multi_cleared", multi0, 0);
         check("multi_held_after", held0, 1);
      end
      check("multi_release_no_event", ev0, 0);

      // Auto-repeat on the second instance.
      rdy1 = 1'b1; pressed = 16'h0400;
      do_reset();
      ev1 = 0;
      run_frames(3);
      check("rep_commit_ev", ev1, 1);
      check("rep_commit_key", lk1, 10);
      for (int f = 1; f <= 8; f++) begin
         ev1 = 0;
         run_frames(1);
         check("rep_event", ev1, 32'(rep_expected(f, 2, 1)));
         check("rep_held", held1, 1);
      end
      check("rep_key", lk1, 10);
      ev1 = 0;
      pressed = '0;
      run_frames(2);
      check("rep_release_held", held1, 1);
      run_frames(1);
      check("rep_release_idle", held1, 0);
      check("rep_release_no_event", ev1, 0);

      // Reset while an event is pending and overflow is set, mid-frame.
      rdy0 = 1'b0; pressed = 16'h0008;
      do_reset();
      run_frames(3);
      pressed = '0;
      run_frames(3);
      pressed = 16'h1000;
      run_frames(3);
      check("rst_pre_valid", v0, 1);
      check("rst_pre_ovf", ovf0, 1);
      repeat (5) tick();
      reset = 1'b1;
      tick();
      check("rst_key", key0, 0);
      check("rst_valid", v0, 0);
      check("rst_held", held0, 0);
      check("rst_multi", multi0, 0);
      check("rst_ovf", ovf0, 0);
      check("rst_kpc", kpc0, 4'b1110);
      reset = 1'b0;
      repeat (3) tick();
      check("rst_div_col0", kpc0, 4'b1110);
      tick();
      check("rst_div_col1", kpc0, 4'b1101);

      // Randomized frames and random ready against a frame-level model.
      pressed = '0;
      do_reset();
      res_q.delete();
      mheld = 0; mheld_idx = 0; mvalid = 0; mkey = 0; movf = 0; mmulti = 0;
      for (int fr = 0; fr < 60; fr++) begin
         if (fr == 0 || $urandom_range(0, 9) >= 6) begin
            case ($urandom_range(0, 3))
               0:       pressed = '0;
               1, 2:    pressed = 16'(1) << $urandom_range(0, 15);
               default: pressed = (16'(1) << $urandom_range(0, 15)) |
                                  (16'(1) << $urandom_range(0, 15));
            endcase
         end
         for (int t = 0; t < 16; t++) begin
            rdy0 = 1'($urandom_range(0, 1));
            ev = 0; ev_key = 0;
            if (t == 15) begin
               if ($countones(pressed) == 0) r = -1;
               else if ($countones(pressed) > 1) r = -2;
               else begin
                  r = 0;
                  for (int b = 0; b < 16; b++) if (pressed[b]) r = b;
               end
               res_q.push_back(r);
               mmulti = (r == -2);
               allsame = (res_q.size() >= 3);
               for (int k = 1; k <= 3 && allsame; k++)
                  if (res_q[res_q.size() - k] != r) allsame = 0;
               if (allsame && r >= 0 && (!mheld || mheld_idx != r)) begin
                  mheld = 1; mheld_idx = r; ev = 1; ev_key = r;
               end else if (allsame && r == -1) begin
                  mheld = 0;
               end
            end
            if (mvalid && rdy0) begin
               mvalid = ev;
               if (ev) mkey = ev_key;
            end else if (mvalid) begin
               if (ev) movf = 1;
            end else if (ev) begin
               mvalid = 1; mkey = ev_key;
            end
            tick();
            check("rnd_valid", v0, 32'(mvalid));
            check("rnd_key", key0, mkey);
            check("rnd_ovf", ovf0, 32'(movf));
            if (t == 15) begin
               check("rnd_held", held0, 32'(mheld));
               check("rnd_multi", multi0, 32'(mmulti));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
